// File: rtl/selector4_sched_pkg.sv
// rtl/selector4_sched_pkg.sv - shared constants, state type and index helper for selector4_sched
package selector4_sched_pkg;

    localparam int LANES   = 4;
    localparam int IDX_W   = 3;
    localparam int LEN_W   = 2;
    localparam int NUM_REQ = 2;
    localparam int SEL_W   = LANES * IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Per-lane starting index advanced by the beat number; wraps by IDX_W-bit truncation.
    function automatic logic [SEL_W-1:0] idx_add(input logic [SEL_W-1:0] base,
                                                 input logic [LEN_W-1:0] k);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*IDX_W +: IDX_W] = base[i*IDX_W +: IDX_W] + IDX_W'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/selector4_sched_rr_arb2.sv
// rtl/selector4_sched_rr_arb2.sv - two-way round-robin arbiter with pointer update on accept
module sched_rr_arb2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    // ptr_q = 0 favours requester 0, 1 favours requester 1
    logic ptr_q;

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
        end else if (accept_i) begin
            ptr_q <= grant_o[0];
        end
    end

endmodule

// File: rtl/selector4_sched.sv
// rtl/selector4_sched.sv - round-robin burst scheduler driving the select inputs of a shared selector4
module selector4_sched
    import selector4_sched_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_REQ-1:0]          REQ_VALID,
    output logic [NUM_REQ-1:0]          REQ_READY,
    input  logic [NUM_REQ*SEL_W-1:0]    REQ_IDX_A,
    input  logic [NUM_REQ*SEL_W-1:0]    REQ_IDX_B,
    input  logic [NUM_REQ*LANES-1:0]    REQ_SRC,
    input  logic [NUM_REQ*LEN_W-1:0]    REQ_LEN,
    output logic [SEL_W-1:0]            SEL_A_OUT,
    output logic [SEL_W-1:0]            SEL_B_OUT,
    output logic [LANES-1:0]            SEL_OUT,
    output logic                        RSP_VALID,
    output logic                        RSP_ID,
    output logic                        RSP_LAST,
    output logic                        BUSY
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_a_q, idx_b_q;
    logic [LANES-1:0]   src_q;
    logic [LEN_W-1:0]   len_q, beat_q;
    logic               id_q;
    logic [SEL_W-1:0]   sel_a_q, sel_b_q;
    logic [LANES-1:0]   sel_q;
    logic               rsp_valid_q, rsp_id_q, rsp_last_q;

    logic [1:0]         grant;
    logic               last_beat, ready_window, accept, win_id;

    assign last_beat    = (state_q == BURST) && (beat_q == len_q);
    assign ready_window = !RESET && ((state_q == IDLE) || last_beat);
    assign accept       = |(REQ_VALID & REQ_READY);
    assign win_id       = grant[1];

    sched_rr_arb2 u_arb (
        .clk_i    (CLK),
        .reset_i  (RESET),
        .valid_i  (REQ_VALID),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (last_beat && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = ready_window ? grant : 2'b00;
        BUSY      = (state_q == BURST);
    end

    // SEL registers are loaded with beat 0 at accept so the beat appears the following cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_a_q <= '0;
            idx_b_q <= '0;
            src_q   <= '0;
            len_q   <= '0;
            id_q    <= 1'b0;
            beat_q  <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            sel_q   <= '0;
        end else if (accept) begin
            idx_a_q <= REQ_IDX_A[int'(win_id)*SEL_W +: SEL_W];
            idx_b_q <= REQ_IDX_B[int'(win_id)*SEL_W +: SEL_W];
            src_q   <= REQ_SRC[int'(win_id)*LANES +: LANES];
            len_q   <= REQ_LEN[int'(win_id)*LEN_W +: LEN_W];
            id_q    <= win_id;
            beat_q  <= '0;
            sel_a_q <= REQ_IDX_A[int'(win_id)*SEL_W +: SEL_W];
            sel_b_q <= REQ_IDX_B[int'(win_id)*SEL_W +: SEL_W];
            sel_q   <= REQ_SRC[int'(win_id)*LANES +: LANES];
        end else if ((state_q == BURST) && !last_beat) begin
            beat_q  <= beat_q + LEN_W'(1);
            sel_a_q <= idx_add(idx_a_q, beat_q + LEN_W'(1));
            sel_b_q <= idx_add(idx_b_q, beat_q + LEN_W'(1));
        end
    end

    // One-cycle delay matching the selector4 output register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == BURST);
            rsp_id_q    <= (state_q == BURST) ? id_q : 1'b0;
            rsp_last_q  <= last_beat;
        end
    end

    assign SEL_A_OUT = sel_a_q;
    assign SEL_B_OUT = sel_b_q;
    assign SEL_OUT   = sel_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_LAST  = rsp_last_q;

endmodule

// File: tb/tb_selector4_sched.sv
// tb/tb_selector4_sched.sv - directed and random bench for selector4_sched against a beat-queue model
module tb_selector4_sched;
    import selector4_sched_pkg::*;

    logic                     CLK = 1'b0;
    logic                     RESET;
    logic [1:0]               REQ_VALID;
    logic [1:0]               REQ_READY;
    logic [2*SEL_W-1:0]       REQ_IDX_A, REQ_IDX_B;
    logic [2*LANES-1:0]       REQ_SRC;
    logic [2*LEN_W-1:0]       REQ_LEN;
    logic [SEL_W-1:0]         SEL_A_OUT, SEL_B_OUT;
    logic [LANES-1:0]         SEL_OUT;
    logic                     RSP_VALID, RSP_ID, RSP_LAST, BUSY;

    always #5 CLK = ~CLK;

    selector4_sched dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_IDX_A(REQ_IDX_A), .REQ_IDX_B(REQ_IDX_B), .REQ_SRC(REQ_SRC), .REQ_LEN(REQ_LEN),
        .SEL_A_OUT(SEL_A_OUT), .SEL_B_OUT(SEL_B_OUT), .SEL_OUT(SEL_OUT),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_LAST(RSP_LAST), .BUSY(BUSY)
    );

    logic [31:0] data_a = 32'h76543210;
    logic [31:0] data_b = 32'hFEDCBA98;
    logic [15:0] nib_q;

    // Behavioural selector4 with registered output.
    always @(posedge CLK) begin
        for (int i = 0; i < LANES; i++) begin
            nib_q[i*4 +: 4] <= SEL_OUT[i] ? data_a[int'(SEL_A_OUT[i*3 +: 3])*4 +: 4]
                                          : data_b[int'(SEL_B_OUT[i*3 +: 3])*4 +: 4];
        end
    end

    typedef struct {
        logic [SEL_W-1:0] a;
        logic [SEL_W-1:0] b;
        logic [LANES-1:0] src;
        logic             id;
        logic             last;
    } beat_t;

    beat_t            pend[$];
    beat_t            rsp_exp;
    bit               rsp_v = 0;
    bit               ptr = 0;
    bit               armed = 0;
    logic [SEL_W-1:0] exp_a = '0, exp_b = '0;
    logic [LANES-1:0] exp_src = '0;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_nib(input beat_t bt);
        logic [15:0] n;
        for (int i = 0; i < LANES; i++) begin
            n[i*4 +: 4] = bt.src[i] ? data_a[int'(bt.a[i*3 +: 3])*4 +: 4]
                                    : data_b[int'(bt.b[i*3 +: 3])*4 +: 4];
        end
        return n;
    endfunction

    task automatic set_req(input int r, input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b,
                           input logic [LANES-1:0] s, input logic [LEN_W-1:0] l);
        REQ_IDX_A[r*SEL_W +: SEL_W] = a;
        REQ_IDX_B[r*SEL_W +: SEL_W] = b;
        REQ_SRC[r*LANES +: LANES]   = s;
        REQ_LEN[r*LEN_W +: LEN_W]   = l;
    endtask

    // Called at a negedge after inputs are driven: checks this cycle, then advances the model over the next posedge.
    task automatic cycle();
        logic [1:0] win, exp_ready;
        int         id, len;
        beat_t      bt;
        #1;
        win = (REQ_VALID == 2'b11) ? (ptr ? 2'b10 : 2'b01) : REQ_VALID;
        exp_ready = (!RESET && pend.size() <= 1) ? win : 2'b00;
        if (armed) begin
            chk("req_ready", 32'(REQ_READY), 32'(exp_ready));
            chk("busy", 32'(BUSY), 32'(pend.size() > 0));
            chk("sel_a", 32'(SEL_A_OUT), 32'(exp_a));
            chk("sel_b", 32'(SEL_B_OUT), 32'(exp_b));
            chk("sel", 32'(SEL_OUT), 32'(exp_src));
            chk("rsp_valid", 32'(RSP_VALID), 32'(rsp_v));
            if (rsp_v) begin
                chk("rsp_id", 32'(RSP_ID), 32'(rsp_exp.id));
                chk("rsp_last", 32'(RSP_LAST), 32'(rsp_exp.last));
                chk("nibble", 32'(nib_q), 32'(exp_nib(rsp_exp)));
            end
        end
        if (RESET) begin
            pend.delete();
            rsp_v = 0;
            ptr = 0;
            exp_a = '0; exp_b = '0; exp_src = '0;
            armed = 1;
        end else begin
            rsp_v = (pend.size() > 0);
            if (rsp_v) rsp_exp = pend.pop_front();
            if (exp_ready != 2'b00) begin
                id  = exp_ready[1] ? 1 : 0;
                len = int'(REQ_LEN[id*LEN_W +: LEN_W]);
                for (int k = 0; k <= len; k++) begin
                    for (int i = 0; i < LANES; i++) begin
                        bt.a[i*3 +: 3] = 3'((int'(REQ_IDX_A[id*SEL_W + i*3 +: 3]) + k) % 8);
                        bt.b[i*3 +: 3] = 3'((int'(REQ_IDX_B[id*SEL_W + i*3 +: 3]) + k) % 8);
                    end
                    bt.src  = REQ_SRC[id*LANES +: LANES];
                    bt.id   = 1'(id);
                    bt.last = (k == len);
                    pend.push_back(bt);
                end
                ptr = (id == 0);
            end
            if (pend.size() > 0) begin
                exp_a = pend[0].a; exp_b = pend[0].b; exp_src = pend[0].src;
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            cycle();
        end
    endtask

    initial begin
        RESET = 1'b1;
        REQ_VALID = 2'b11;
        REQ_IDX_A = '0; REQ_IDX_B = '0; REQ_SRC = '0; REQ_LEN = '0;

        // Reset with both requesters asking
        run(2);
        chk("reset_ready", 32'(REQ_READY), 32'h0);
        RESET = 1'b0;
        REQ_VALID = 2'b00;
        run(1);

        // Single beat from requester 0
        @(negedge CLK);
        set_req(0, 12'h688, 12'h000, 4'hF, 2'd0);
        REQ_VALID = 2'b01;
        cycle();
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        chk("t2_sel_a", 32'(SEL_A_OUT), 32'h688);
        run(1);
        chk("t2_nibble", 32'(nib_q), 32'h3210);
        chk("t2_last", 32'(RSP_LAST), 32'h1);
        run(1);

        // Four-beat burst from requester 1 wrapping 6,7,0,1
        @(negedge CLK);
        set_req(1, 12'h000, 12'hDB6, 4'h0, 2'd3);
        REQ_VALID = 2'b10;
        cycle();
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        run(1);
        chk("t3_sel_b_beat1", 32'(SEL_B_OUT), 32'hFFF);
        run(1);
        chk("t3_sel_b_beat2", 32'(SEL_B_OUT), 32'h000);
        run(4);

        // Contention from reset, back-to-back grants
        @(negedge CLK);
        RESET = 1'b1;
        cycle();
        @(negedge CLK);
        RESET = 1'b0;
        set_req(0, 12'h123, 12'h456, 4'h5, 2'd1);
        set_req(1, 12'h321, 12'h654, 4'hA, 2'd1);
        REQ_VALID = 2'b11;
        cycle();
        run(5);
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        run(4);

        // No preemption of a four-beat burst
        @(negedge CLK);
        set_req(0, 12'h0C5, 12'h2B1, 4'h3, 2'd3);
        REQ_VALID = 2'b01;
        cycle();
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        @(negedge CLK);
        REQ_VALID = 2'b10;
        cycle();
        run(3);
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        run(6);

        // Reset during beat 2, then clean restart favouring requester 0
        @(negedge CLK);
        set_req(0, 12'h777, 12'h111, 4'h9, 2'd3);
        REQ_VALID = 2'b01;
        cycle();
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        run(1);
        @(negedge CLK);
        RESET = 1'b1;
        cycle();
        @(negedge CLK);
        RESET = 1'b0;
        REQ_VALID = 2'b11;
        cycle();
        chk("t6_rsp_after_reset", 32'(RSP_VALID), 32'h0);
        chk("t6_ready_favours0", 32'(REQ_READY), 32'h1);
        @(negedge CLK);
        REQ_VALID = 2'b00;
        cycle();
        run(3);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            RESET = ($urandom_range(0, 79) == 0);
            REQ_VALID = 2'($urandom_range(0, 3));
            REQ_IDX_A = 24'($urandom);
            REQ_IDX_B = 24'($urandom);
            REQ_SRC = 8'($urandom);
            REQ_LEN = 4'($urandom);
            cycle();
        end
        @(negedge CLK);
        RESET = 1'b0;
        REQ_VALID = 2'b00;
        cycle();
        run(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
